// File: rtl/capture_sched_if.sv
// ---------------------------------------------------------------------------
// capture_sched_if
//   Bundles every non-clock/reset signal of the capture scheduler.
//   master : the scheduler (drives pkt_ready, writer control, descriptors)
//   slave  : the surrounding system (packet source, writer, host)
//
//   pkt_valid/pkt_len/pkt_ready      packet length offer handshake
//   wr_ctrl/wr_ctrl_rdy              writer start pulse / writer done
//   control/pkt_begin/pkt_end        writer job description
//   free_valid/free_bytes            host releases region bytes
//   desc_valid/desc_addr/len/skip    committed packet descriptor
//   drop_cnt/busy/err                status
// ---------------------------------------------------------------------------
interface capture_sched_if;
    logic        pkt_valid;
    logic [15:0] pkt_len;
    logic        pkt_ready;
    logic        wr_ctrl;
    logic        wr_ctrl_rdy;
    logic [31:0] control;
    logic [31:0] pkt_begin;
    logic [31:0] pkt_end;
    logic        free_valid;
    logic [31:0] free_bytes;
    logic        desc_valid;
    logic [31:0] desc_addr;
    logic [15:0] desc_len;
    logic [31:0] desc_skip;
    logic [15:0] drop_cnt;
    logic        busy;
    logic        err;

    modport master (
        input  pkt_valid, pkt_len, wr_ctrl_rdy, free_valid, free_bytes,
        output pkt_ready, wr_ctrl, control, pkt_begin, pkt_end,
               desc_valid, desc_addr, desc_len, desc_skip, drop_cnt, busy, err
    );

    modport slave (
        output pkt_valid, pkt_len, wr_ctrl_rdy, free_valid, free_bytes,
        input  pkt_ready, wr_ctrl, control, pkt_begin, pkt_end,
               desc_valid, desc_addr, desc_len, desc_skip, drop_cnt, busy, err
    );
endinterface

// File: rtl/capture_sched.sv
// ---------------------------------------------------------------------------
// capture_sched
//   Sequences the packet writer for each captured packet. Every accepted
//   length gets a word-aligned slot in a circular region [BASE_ADDR,
//   BASE_ADDR+REGION_BYTES). A packet that does not fit in the tail of the
//   region is placed at BASE_ADDR and the tail is reported as skipped. The
//   scheduler stalls while the region lacks room, pulses wr_ctrl, waits for
//   wr_ctrl_rdy, then commits the slot and emits a one-cycle descriptor.
//
//   Ports:
//     clk    clock
//     reset  asynchronous active-high reset
//     bus    capture_sched_if.master (see interface file for signal list)
//
//   Optional feature macro: WATCHDOG_EN
//     defined   : WAIT is bounded by TIMEOUT cycles; on expiry the block
//                 enters a terminal ERR state with err=1 until reset.
//     undefined : WAIT is unbounded and err is tied to 0.
// ---------------------------------------------------------------------------
module capture_sched #(
    parameter logic [31:0] BASE_ADDR     = 32'h0000_0000,
    parameter int unsigned REGION_BYTES  = 65536,
    parameter int unsigned MAX_PKT_BYTES = 2048
`ifdef WATCHDOG_EN
    ,
    parameter int unsigned TIMEOUT       = 4096
`endif
) (
    input  logic             clk,
    input  logic             reset,
    capture_sched_if.master  bus
);

`ifdef WATCHDOG_EN
    typedef enum logic [2:0] {IDLE, CHECK, START, WAIT, COMMIT, ERR} state_t;
`else
    typedef enum logic [2:0] {IDLE, CHECK, START, WAIT, COMMIT} state_t;
`endif

    // All address/occupancy math is done 33 bits wide so nothing can wrap.
    localparam logic [32:0] END_ADDR = {1'b0, BASE_ADDR} + 33'(REGION_BYTES);
    localparam logic [32:0] REGION_W = 33'(REGION_BYTES);
    localparam logic [31:0] MAX_LEN  = 32'(MAX_PKT_BYTES);

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    function automatic logic [32:0] sat_sub33(input logic [32:0] a, input logic [32:0] b);
        return (a > b) ? a - b : 33'd0;
    endfunction

    state_t      state;
    logic [31:0] wr_ptr;
    logic [32:0] occupancy;

    // Per-packet working values, captured when the slot is granted.
    logic [15:0] len_q;
    logic [32:0] lenr_q;
    logic [31:0] begin_q;
    logic [31:0] skip_q;
    logic [32:0] need_q;

    logic        wr_ctrl_q;
    logic [31:0] control_q;
    logic [31:0] pkt_begin_q;
    logic [31:0] pkt_end_q;
    logic        desc_valid_q;
    logic [31:0] desc_addr_q;
    logic [15:0] desc_len_q;
    logic [31:0] desc_skip_q;
    logic [15:0] drop_cnt_q;
    logic        err_c;

`ifdef WATCHDOG_EN
    logic        err_q;
    logic [31:0] wd_cnt;
    assign err_c = err_q;
`else
    assign err_c = 1'b0;
`endif

    logic        pkt_ready_c;
    logic        accept_c;
    logic        len_ok_c;
    logic [32:0] lenr_c;
    logic [32:0] tail_c;
    logic        wrap_c;
    logic [31:0] begin_c;
    logic [32:0] skip_c;
    logic [32:0] need_c;
    logic        fits_c;
    logic [32:0] pkt_end_c;
    logic [32:0] next_ptr_c;
    logic [32:0] occ_commit_c;
    logic        unused_bits;

    assign pkt_ready_c = (state == IDLE) && !err_c;
    assign accept_c    = bus.pkt_valid && pkt_ready_c;
    assign len_ok_c    = (bus.pkt_len != 16'd0) && ({16'd0, bus.pkt_len} <= MAX_LEN);

    // Slot placement for the latched length against the current write pointer.
    assign lenr_c     = ({17'd0, len_q} + 33'd3) & ~33'd3;
    assign tail_c     = END_ADDR - {1'b0, wr_ptr};
    assign wrap_c     = lenr_c > tail_c;
    assign begin_c    = wrap_c ? BASE_ADDR : wr_ptr;
    assign skip_c     = wrap_c ? tail_c : 33'd0;
    assign need_c     = lenr_c + skip_c;
    assign fits_c     = (occupancy + need_c) <= REGION_W;
    assign pkt_end_c  = {1'b0, begin_c} + lenr_c - 33'd4;
    assign next_ptr_c = {1'b0, begin_q} + lenr_q;

    // Commit and host free may land on the same edge; the net is applied.
    assign occ_commit_c = (state == COMMIT) ? occupancy + need_q : occupancy;

    // pkt_end never exceeds 32 bits; its carry bit is intentionally dropped.
    assign unused_bits = pkt_end_c[32];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            wr_ptr       <= BASE_ADDR;
            occupancy    <= '0;
            wr_ctrl_q    <= 1'b0;
            control_q    <= '0;
            pkt_begin_q  <= '0;
            pkt_end_q    <= '0;
            desc_valid_q <= 1'b0;
            desc_addr_q  <= '0;
            desc_len_q   <= '0;
            desc_skip_q  <= '0;
            drop_cnt_q   <= '0;
`ifdef WATCHDOG_EN
            err_q        <= 1'b0;
            wd_cnt       <= '0;
`endif
        end else begin
            wr_ctrl_q    <= 1'b0;
            desc_valid_q <= 1'b0;
            occupancy    <= bus.free_valid ? sat_sub33(occ_commit_c, {1'b0, bus.free_bytes})
                                           : occ_commit_c;
            case (state)
                IDLE: begin
                    if (accept_c) begin
                        if (len_ok_c) state <= CHECK;
                        else          drop_cnt_q <= sat_inc16(drop_cnt_q);
                    end
                end
                CHECK: begin
                    // Re-evaluated every cycle until frees make room.
                    if (fits_c) begin
                        state       <= START;
                        wr_ctrl_q   <= 1'b1;
                        control_q   <= {1'b1, 15'd0, len_q};
                        pkt_begin_q <= begin_c;
                        pkt_end_q   <= pkt_end_c[31:0];
                    end
                end
                START: begin
                    state <= WAIT;
`ifdef WATCHDOG_EN
                    wd_cnt <= '0;
`endif
                end
                WAIT: begin
                    if (bus.wr_ctrl_rdy) begin
                        state        <= COMMIT;
                        desc_valid_q <= 1'b1;
                        desc_addr_q  <= begin_q;
                        desc_len_q   <= len_q;
                        desc_skip_q  <= skip_q;
                    end
`ifdef WATCHDOG_EN
                    else if (wd_cnt == 32'(TIMEOUT - 1)) begin
                        state <= ERR;
                        err_q <= 1'b1;
                    end else begin
                        wd_cnt <= wd_cnt + 32'd1;
                    end
`endif
                end
                COMMIT: begin
                    wr_ptr <= (next_ptr_c == END_ADDR) ? BASE_ADDR : next_ptr_c[31:0];
                    state  <= IDLE;
                end
`ifdef WATCHDOG_EN
                ERR: state <= ERR;
`endif
                default: state <= IDLE;
            endcase
        end
    end

    // Working values only matter between accept and commit; no reset needed.
    always_ff @(posedge clk) begin
        if (accept_c && len_ok_c) begin
            len_q <= bus.pkt_len;
        end
        if ((state == CHECK) && fits_c) begin
            lenr_q  <= lenr_c;
            begin_q <= begin_c;
            skip_q  <= skip_c[31:0];
            need_q  <= need_c;
        end
    end

    assign bus.pkt_ready  = pkt_ready_c;
    assign bus.wr_ctrl    = wr_ctrl_q;
    assign bus.control    = control_q;
    assign bus.pkt_begin  = pkt_begin_q;
    assign bus.pkt_end    = pkt_end_q;
    assign bus.desc_valid = desc_valid_q;
    assign bus.desc_addr  = desc_addr_q;
    assign bus.desc_len   = desc_len_q;
    assign bus.desc_skip  = desc_skip_q;
    assign bus.drop_cnt   = drop_cnt_q;
    assign bus.busy       = (state != IDLE);
    assign bus.err        = err_c;

endmodule

// File: tb/tb_capture_sched.sv
module tb_capture_sched;
    localparam logic [31:0] BASE = 32'h1000;
    localparam int          REG  = 256;
    localparam int          MAXP = 2048;
    localparam int          TMO  = 16;

    logic clk;
    logic reset;

    capture_sched_if bus ();

    capture_sched #(
        .BASE_ADDR     (BASE),
        .REGION_BYTES  (REG),
        .MAX_PKT_BYTES (MAXP)
`ifdef WATCHDOG_EN
        ,
        .TIMEOUT       (TMO)
`endif
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (transaction timeline) ----------------
    longint      m_wptr, m_occ, m_begin, m_skip, m_lenr;
    int          m_drops, m_len;
    bit          m_inflight, m_placing, m_err;
    logic [31:0] m_control, m_pbeg, m_pend;
    int          start_c, rdy_c, cyc;

    task automatic model_reset();
        m_wptr = BASE; m_occ = 0; m_drops = 0; m_inflight = 0; m_placing = 0;
        m_err = 0; m_control = 0; m_pbeg = 0; m_pend = 0; start_c = -1; rdy_c = -1;
        m_begin = 0; m_skip = 0; m_lenr = 0; m_len = 0;
    endtask

    // Placement rule: round length up to whole words; if it does not fit
    // before the region end, start over at the base and skip the tail.
    task automatic place(input longint wptr, input int len,
                         output longint b, output longint s, output longint lr);
        longint tail;
        lr   = ((len + 3) / 4) * 4;
        tail = longint'(BASE) + REG - wptr;
        if (lr > tail) begin b = BASE; s = tail; end
        else           begin b = wptr; s = 0;    end
    endtask

    initial begin
        bit exp_desc;
        longint b, s, lr;
        cyc = 0;
        model_reset();
        forever begin
            @(negedge clk);
            if (reset) begin
                chk("rst_wr_ctrl", bus.wr_ctrl, 0);
                chk("rst_desc_valid", bus.desc_valid, 0);
                chk("rst_drop_cnt", bus.drop_cnt, 0);
                chk("rst_busy", bus.busy, 0);
                chk("rst_err", bus.err, 0);
                chk("rst_pkt_begin", bus.pkt_begin, 0);
                model_reset();
            end else begin
                exp_desc = (rdy_c >= 0) && (cyc == rdy_c + 1);
                chk("m_pkt_ready", bus.pkt_ready, !m_inflight && !m_err);
                chk("m_wr_ctrl", bus.wr_ctrl, (start_c >= 0) && (cyc == start_c));
                chk("m_desc_valid", bus.desc_valid, exp_desc);
                chk("m_busy", bus.busy, m_inflight || m_err);
                chk("m_drop_cnt", bus.drop_cnt, 32'(m_drops));
                chk("m_err", bus.err, m_err);
                chk("m_control", bus.control, m_control);
                chk("m_pkt_begin", bus.pkt_begin, m_pbeg);
                chk("m_pkt_end", bus.pkt_end, m_pend);
                if (exp_desc) begin
                    chk("m_desc_addr", bus.desc_addr, 32'(m_begin));
                    chk("m_desc_len", bus.desc_len, 32'(m_len));
                    chk("m_desc_skip", bus.desc_skip, 32'(m_skip));
                end

                // advance the model with the inputs sampled at the coming edge
                if (!m_inflight && !m_err) begin
                    if (bus.pkt_valid) begin
                        if (bus.pkt_len == 0 || int'(bus.pkt_len) > MAXP) begin
                            if (m_drops < 16'hFFFF) m_drops++;
                        end else begin
                            m_inflight = 1; m_placing = 1; m_len = int'(bus.pkt_len);
                        end
                    end
                end else if (m_placing) begin
                    place(m_wptr, m_len, b, s, lr);
                    if (m_occ + lr + s <= REG) begin
                        m_placing = 0; start_c = cyc + 1;
                        m_begin = b; m_skip = s; m_lenr = lr;
                        m_control = 32'h8000_0000 | 32'(m_len);
                        m_pbeg = 32'(b); m_pend = 32'(b + lr - 4);
                    end
                end else if (start_c >= 0 && cyc > start_c && rdy_c < 0 && m_inflight) begin
                    if (bus.wr_ctrl_rdy) rdy_c = cyc;
`ifdef WATCHDOG_EN
                    else if (cyc == start_c + TMO) begin m_err = 1; m_inflight = 0; end
`endif
                end else if (rdy_c >= 0 && cyc == rdy_c + 1) begin
                    m_wptr = m_begin + m_lenr;
                    if (m_wptr == longint'(BASE) + REG) m_wptr = BASE;
                    m_occ = m_occ + m_lenr + m_skip;
                    m_inflight = 0; start_c = -1; rdy_c = -1;
                end
                if (bus.free_valid)
                    m_occ = (m_occ > longint'(bus.free_bytes)) ? m_occ - longint'(bus.free_bytes) : 0;
            end
            cyc++;
        end
    end

    // ---------------- directed stimulus with literal expectations ----------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int len);
        bus.pkt_valid = 1'b1;
        bus.pkt_len   = 16'(len);
        tick();
        bus.pkt_valid = 1'b0;
    endtask

    task automatic free(input int n);
        bus.free_valid = 1'b1;
        bus.free_bytes = 32'(n);
        tick();
        bus.free_valid = 1'b0;
    endtask

    task automatic wait_wr(input int budget, output bit seen);
        seen = 0;
        for (int i = 0; i < budget; i++) begin
            if (bus.wr_ctrl) begin seen = 1; break; end
            tick();
        end
    endtask

    // Writer answers 5 cycles after wr_ctrl; descriptor must follow at once.
    task automatic finish_pkt(input string tag, input int len,
                              input logic [31:0] e_begin, input logic [31:0] e_skip);
        repeat (5) tick();
        bus.wr_ctrl_rdy = 1'b1;
        tick();
        bus.wr_ctrl_rdy = 1'b0;
        chk({tag, "_desc_valid"}, bus.desc_valid, 1);
        chk({tag, "_desc_addr"}, bus.desc_addr, e_begin);
        chk({tag, "_desc_len"}, bus.desc_len, 32'(len));
        chk({tag, "_desc_skip"}, bus.desc_skip, e_skip);
        tick();
    endtask

    task automatic run_pkt(input string tag, input int len, input logic [31:0] e_begin,
                           input logic [31:0] e_end, input logic [31:0] e_skip,
                           input logic [31:0] e_ctrl);
        bit seen;
        send(len);
        wait_wr(6, seen);
        chk({tag, "_wr_seen"}, seen, 1);
        chk({tag, "_pkt_begin"}, bus.pkt_begin, e_begin);
        chk({tag, "_pkt_end"}, bus.pkt_end, e_end);
        chk({tag, "_control"}, bus.control, e_ctrl);
        finish_pkt(tag, len, e_begin, e_skip);
    endtask

    initial begin
        bit seen;
        int wcnt;
        bus.pkt_valid   = 1'b0;
        bus.pkt_len     = 16'd0;
        bus.wr_ctrl_rdy = 1'b0;
        bus.free_valid  = 1'b0;
        bus.free_bytes  = 32'd0;
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        chk("reset_pkt_ready", bus.pkt_ready, 1);
        chk("reset_busy", bus.busy, 0);
        chk("reset_wr_ctrl", bus.wr_ctrl, 0);
        tick();

        run_pkt("single", 10, 32'h1000, 32'h1008, 0, 32'h8000_000A);
        free(12);
        run_pkt("second", 228, 32'h100C, 32'h10EC, 0, 32'h8000_00E4);
        free(228);
        run_pkt("wrap", 20, 32'h1000, 32'h1010, 16, 32'h8000_0014);
        free(36);
        run_pkt("exact_end", 236, 32'h1014, 32'h10FC, 0, 32'h8000_00EC);
        run_pkt("after_wrap", 12, 32'h1000, 32'h1008, 0, 32'h8000_000C);

        // occupancy is now 248: a 12-byte packet must stall until 8 bytes free
        send(12);
        wcnt = 0;
        repeat (10) begin
            if (bus.wr_ctrl) wcnt++;
            tick();
        end
        chk("stall_no_wr", 32'(wcnt), 0);
        chk("stall_busy", bus.busy, 1);
        free(8);
        wait_wr(3, seen);
        chk("unstall_wr_seen", seen, 1);
        chk("unstall_pkt_begin", bus.pkt_begin, 32'h100C);
        chk("unstall_pkt_end", bus.pkt_end, 32'h1014);
        finish_pkt("unstall", 12, 32'h100C, 0);
        free(252);

        send(0);
        tick();
        send(4000);
        chk("drop_cnt", bus.drop_cnt, 2);
        chk("drop_pkt_ready", bus.pkt_ready, 1);
        tick();

        // reset while the writer is busy: packet abandoned, no descriptor
        send(16);
        wait_wr(6, seen);
        chk("rstwait_wr_seen", seen, 1);
        tick();
        tick();
        reset = 1'b1;
        #1;
        chk("rstwait_wr_ctrl", bus.wr_ctrl, 0);
        chk("rstwait_desc_valid", bus.desc_valid, 0);
        chk("rstwait_drop_cnt", bus.drop_cnt, 0);
        chk("rstwait_err", bus.err, 0);
        chk("rstwait_busy", bus.busy, 0);
        tick();
        reset = 1'b0;
        chk("rstwait_pkt_ready", bus.pkt_ready, 1);
        tick();

        // writer never answers
        send(8);
        wait_wr(6, seen);
        chk("hang_wr_seen", seen, 1);
        chk("hang_pkt_begin", bus.pkt_begin, 32'h1000);
`ifdef WATCHDOG_EN
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus.err) begin seen = 1; break; end
            tick();
        end
        chk("wd_err_seen", seen, 1);
        chk("wd_pkt_ready", bus.pkt_ready, 0);
        chk("wd_desc_valid", bus.desc_valid, 0);
`else
        repeat (1000) tick();
        chk("hang_busy", bus.busy, 1);
        chk("hang_err", bus.err, 0);
        chk("hang_pkt_ready", bus.pkt_ready, 0);
`endif
        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/capture_sched.md
Name:
capture_sched

Overview:
- Scheduler that sequences wr_ctrl for each captured packet.
- Allocates each packet a word-aligned slot in a circular memory region and drives wr_ctrl's start/control/pkt_begin/pkt_end.
- Waits for wr_ctrl_rdy, then commits the slot and emits a descriptor to the host side.
- Tracks region occupancy against host frees and back-pressures the packet source when the region is full.

Parameters:
- BASE_ADDR, 32'h0000_0000: byte address of the region start; must be word aligned.
- REGION_BYTES, 65536: region size in bytes; multiple of 4.
- MAX_PKT_BYTES, 2048: largest accepted packet length.
- TIMEOUT, 4096: watchdog limit in cycles (only with WATCHDOG_EN).

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- pkt_valid  in  1  a packet length is offered
- pkt_len  in  16  packet length in bytes
- pkt_ready  out  1  scheduler can accept a length
- wr_ctrl  out  1  one-cycle start pulse to the writer
- wr_ctrl_rdy  in  1  writer has finished the packet
- control  out  32  [31]=start flag, [15:0]=pkt_len, other bits 0
- pkt_begin  out  32  first word byte address
- pkt_end  out  32  last word byte address (pkt_begin+len_r-4)
- free_valid  in  1  host releases bytes
- free_bytes  in  32  number of bytes released
- desc_valid  out  1  one-cycle descriptor strobe
- desc_addr  out  32  committed pkt_begin
- desc_len  out  16  committed pkt_len
- desc_skip  out  32  tail bytes skipped before this packet
- drop_cnt  out  16  saturating count of rejected lengths
- busy  out  1  state != IDLE
- err  out  1  sticky watchdog error

Behaviour:
- Reset (asynchronous, active-high): state=IDLE, wr_ptr=BASE_ADDR, occupancy=0. All outputs 0 except pkt_ready.
- pkt_ready = (state==IDLE) && !err. pkt_ready is 1 immediately after reset.
- Accept occurs when pkt_valid && pkt_ready:
  - pkt_len==0 or pkt_len>MAX_PKT_BYTES: drop_cnt+1 (saturates at 16'hFFFF), stay IDLE.
  - Otherwise latch the length and go to CHECK.
- CHECK:
  - len_r = (len+3) & ~3.
  - tail = BASE_ADDR+REGION_BYTES-wr_ptr.
  - If len_r > tail: begin=BASE_ADDR, skip=tail. Else: begin=wr_ptr, skip=0.
  - need = len_r+skip.
  - If occupancy+need > REGION_BYTES, stay in CHECK (stall) and re-evaluate every cycle. Otherwise go to START.
  - All arithmetic is 33-bit internally, so there is no overflow.
- START: wr_ctrl=1 for exactly one cycle, then go to WAIT.
  - control, pkt_begin and pkt_end are valid from START through WAIT.
  - They hold their values until the next START.
- WAIT: on wr_ctrl_rdy go to COMMIT. wr_ctrl_rdy is ignored in every other state.
- COMMIT:
  - wr_ptr = begin+len_r; if the result equals BASE_ADDR+REGION_BYTES, wr_ptr = BASE_ADDR.
  - occupancy += need.
  - desc_valid=1 for one cycle with desc_addr=begin, desc_len=len, desc_skip=skip.
  - Go to IDLE. Latency from accept to wr_ctrl with no stall is 2 cycles.
- free_valid applies in any state: occupancy -= free_bytes, saturating at 0.
  - When free and COMMIT coincide, the net value is applied: occupancy+need-free_bytes.
  - A free that arrives during CHECK is visible to the stall check on the next cycle.
- Host contract: the host frees desc_skip+len_r for each descriptor it consumes.
- Reset in any state: immediate return to reset values. An in-flight packet is abandoned and produces no descriptor.

Optional Feature:
- Macro: WATCHDOG_EN.
- Defined:
  - A cycle counter clears on entry to WAIT and increments each WAIT cycle.
  - When the counter reaches TIMEOUT without wr_ctrl_rdy, go to ERR: err=1, pkt_ready=0, no commit.
  - ERR exits only on reset.
- Undefined: WAIT is unbounded, err is tied to 0, and there is no ERR state.

Test Plan:
- All bench scenarios use BASE_ADDR=32'h1000 and REGION_BYTES=256.
- Reset: assert reset mid-WAIT -> wr_ctrl=0, desc_valid=0, drop_cnt=0, err=0, busy=0 immediately; pkt_ready=1 after release.
- Single packet: pkt_len=10, wr_ctrl_rdy returned 5 cycles after wr_ctrl -> pkt_begin=0x1000, pkt_end=0x1008, control=0x8000_000A; desc_addr=0x1000, desc_len=10, desc_skip=0; next pkt_begin=0x100C.
- Wrap: wr_ptr=0x10F0 and occupancy small, pkt_len=20 -> pkt_begin=0x1000, pkt_end=0x1010, desc_skip=16, occupancy increases by 36. A packet ending exactly at 0x1100 -> next wr_ptr=0x1000.
- Full: occupancy=248, no skip, pkt_len=12 -> stalls in CHECK with no wr_ctrl. free_valid with free_bytes=8 -> wr_ctrl asserted within 2 cycles.
- Drops: pkt_len=0 then pkt_len=4000 -> drop_cnt=2, no wr_ctrl, pkt_ready stays 1.
- Watchdog (WATCHDOG_EN, TIMEOUT=16): wr_ctrl_rdy never returned -> err=1 after 16 WAIT cycles, pkt_ready=0, no desc_valid. Without the macro: still in WAIT after 1000 cycles, err=0.
